icache: RTL and testbench

Direct-mapped instruction cache forming the fetch stage directly upstream of the I→DM pipeline register. It looks up the current PC, returns the instruction combinationally on a hit, and on a miss raises the fetch stall while it refills a 4-word line from the memory side through a req/ready handshake. It also keeps wrap-around hit and miss counters for performance measurement.

---
 rtl/icache.sv | 129 ++++++++++++
 tb/tb_icache.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache for the fetch stage.
// Lookup is combinational. A miss stalls fetch while a 4-word line is
// refilled over a req/ready handshake. Wrap-around hit/miss counters are kept.
module icache #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINES        = 4,
    parameter int LINE_WORDS   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESS_SIZE-1:0]    pc,
    input  logic                       I_stall_in,
    input  logic                       I_flush,
    output logic [31:0]                I_instruction,
    output logic                       I_stall,
    output logic                       mem_req,
    output logic [ADDRESS_SIZE-1:0]    mem_addr,
    input  logic                       mem_ready,
    input  logic [32*LINE_WORDS-1:0]   mem_data,
    output logic [31:0]                perf_hits,
    output logic [31:0]                perf_misses
);

    localparam int IB        = $clog2(LINES);
    localparam int TAG_W     = ADDRESS_SIZE - 4 - IB;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [LINE_BITS-1:0]    data_q [LINES];
    logic [ADDRESS_SIZE-1:0] miss_addr_q, miss_addr_d;
    logic [31:0]             hits_q, hits_d;
    logic [31:0]             misses_q, misses_d;

    logic [IB-1:0]           pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [1:0]              pc_word;
    logic [IB-1:0]           fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    fill;
    logic                    unused_bits;

    // Byte offset of the PC and the line offset of the fill address carry no information.
    assign unused_bits = ^{pc[1:0], miss_addr_q[3:0]};

    assign pc_word  = pc[3:2];
    assign pc_idx   = pc[3+IB:4];
    assign pc_tag   = pc[ADDRESS_SIZE-1:4+IB];
    assign fill_idx = miss_addr_q[3+IB:4];
    assign fill_tag = miss_addr_q[ADDRESS_SIZE-1:4+IB];

    // A lookup only hits while idle, so a line being refilled never forwards early.
    assign hit  = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill = (state_q == REQ) && mem_ready;

    assign I_instruction = hit ? data_q[pc_idx][{pc_word, 5'b0} +: 32] : 32'h0;
    assign I_stall       = I_stall_in | ~hit;
    assign mem_req       = (state_q == REQ);
    assign mem_addr      = miss_addr_q;
    assign perf_hits     = hits_q;
    assign perf_misses   = misses_q;

    // Control state, valid bits and counters; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
        end
    end

    // Line payload and tag storage; written only by a completing fill.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fill_idx] <= mem_data;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    // Next-state logic: miss detection, fill completion, flush and counters.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        hits_d      = hits_q;
        misses_d    = misses_q;

        case (state_q)
            IDLE: begin
                if (hit && !I_stall_in) begin
                    hits_d = hits_q + 32'd1;
                end else if (!hit && !I_stall_in && !I_flush) begin
                    miss_addr_d = {pc[ADDRESS_SIZE-1:4], 4'b0};
                    misses_d    = misses_q + 32'd1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Downstream stall is ignored here: a started fill always completes.
                if (mem_ready) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a fill landing on the same edge.
        if (I_flush) begin
            valid_d = '0;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold miss, hits, eviction, stalls, flush,
// reset abort and counter wrap.
module tb_icache;

    logic          clk;
    logic          reset;
    logic [31:0]   pc;
    logic          I_stall_in;
    logic          I_flush;
    logic [31:0]   I_instruction;
    logic          I_stall;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [127:0]  mem_data;
    logic [31:0]   perf_hits;
    logic [31:0]   perf_misses;

    int vecs = 0;
    int errs = 0;

    localparam logic [127:0] LINE_1000 = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    localparam logic [127:0] LINE_1040 = {32'h10400003, 32'h10400002, 32'h10400001, 32'h10400000};
    localparam logic [127:0] LINE_2000 = {32'h20000003, 32'h20000002, 32'h20000001, 32'h20000000};
    localparam logic [127:0] LINE_3000 = {32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};

    icache #(
        .ADDRESS_SIZE(32),
        .LINES(4),
        .LINE_WORDS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .I_stall_in(I_stall_in),
        .I_flush(I_flush),
        .I_instruction(I_instruction),
        .I_stall(I_stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_data(mem_data),
        .perf_hits(perf_hits),
        .perf_misses(perf_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk); #1;
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL rst_stall got %b want 1", I_stall); end
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL rst_instr got %h want 0", I_instruction); end
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", mem_req); end
        vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        vecs++; if (perf_hits !== 32'h0) begin errs++; $display("FAIL rst_hits got %h want 0", perf_hits); end
        vecs++; if (perf_misses !== 32'h0) begin errs++; $display("FAIL rst_misses got %h want 0", perf_misses); end
    endtask

    task automatic test_cold_miss();
        @(negedge clk); reset = 1'b1; pc = 32'h1000; mem_data = LINE_1000; #1;
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL cold_c0_stall got %b want 1", I_stall); end
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL cold_c0_req got %b want 0", mem_req); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); mem_ready = (c == 3); #1;
            if (c < 4) begin
                vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL cold_c%0d_req got %b want 1", c, mem_req); end
                vecs++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL cold_c%0d_addr got %h want 1000", c, mem_addr); end
                vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL cold_c%0d_stall got %b want 1", c, I_stall); end
            end else begin
                vecs++; if (I_stall !== 1'b0) begin errs++; $display("FAIL cold_c4_stall got %b want 0", I_stall); end
                vecs++; if (I_instruction !== 32'hDEAD0001) begin errs++; $display("FAIL cold_c4_instr got %h want DEAD0001", I_instruction); end
                vecs++; if (perf_misses !== 32'd1) begin errs++; $display("FAIL cold_c4_misses got %0d want 1", perf_misses); end
                vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL cold_c4_req got %b want 0", mem_req); end
            end
        end
    endtask

    task automatic test_same_line_hits();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); pc = 32'h1000 + 32'(4 * k); #1;
            vecs++; if (I_instruction !== 32'hDEAD0001 + 32'(k)) begin errs++; $display("FAIL hit_w%0d_instr got %h want %h", k, I_instruction, 32'hDEAD0001 + 32'(k)); end
            vecs++; if (I_stall !== 1'b0) begin errs++; $display("FAIL hit_w%0d_stall got %b want 0", k, I_stall); end
            vecs++; if (perf_hits !== 32'(k)) begin errs++; $display("FAIL hit_w%0d_count got %0d want %0d", k, perf_hits, k); end
        end
        @(negedge clk); pc = 32'h1000; #1;
        vecs++; if (perf_hits !== 32'd4) begin errs++; $display("FAIL hit_count_end got %0d want 4", perf_hits); end
    endtask

    task automatic test_conflict();
        @(negedge clk); pc = 32'h1040; #1;
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL evict_miss_stall got %b want 1", I_stall); end
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL evict_miss_instr got %h want 0", I_instruction); end
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL evict_req got %b want 1", mem_req); end
        vecs++; if (mem_addr !== 32'h1040) begin errs++; $display("FAIL evict_addr got %h want 1040", mem_addr); end
        vecs++; if (perf_misses !== 32'd2) begin errs++; $display("FAIL evict_misses got %0d want 2", perf_misses); end
        mem_ready = 1'b1; mem_data = LINE_1040;
        @(negedge clk); mem_ready = 1'b0; #1;
        vecs++; if (I_instruction !== 32'h10400000) begin errs++; $display("FAIL evict_fill_instr got %h want 10400000", I_instruction); end
        vecs++; if (I_stall !== 1'b0) begin errs++; $display("FAIL evict_fill_stall got %b want 0", I_stall); end
        @(negedge clk); pc = 32'h1000; #1;
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL evict_old_stall got %b want 1", I_stall); end
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL evict_old_instr got %h want 0", I_instruction); end
        @(negedge clk); #1;
        vecs++; if (mem_addr !== 32'h1000 || mem_req !== 1'b1) begin errs++; $display("FAIL evict_old_req got req=%b addr=%h want req=1 addr=1000", mem_req, mem_addr); end
        mem_ready = 1'b1; mem_data = LINE_1000;
        @(negedge clk); mem_ready = 1'b0; #1;
        vecs++; if (I_instruction !== 32'hDEAD0001) begin errs++; $display("FAIL evict_refill_instr got %h want DEAD0001", I_instruction); end
    endtask

    task automatic test_downstream_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); pc = 32'h2000; I_stall_in = 1'b1; #1;
            vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL dstall_c%0d_req got %b want 0", i, mem_req); end
            vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL dstall_c%0d_stall got %b want 1", i, I_stall); end
        end
        @(negedge clk); I_stall_in = 1'b0; #1;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL dstall_fall_req got %b want 0", mem_req); end
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL dstall_rise_req got %b want 1", mem_req); end
        vecs++; if (mem_addr !== 32'h2000) begin errs++; $display("FAIL dstall_rise_addr got %h want 2000", mem_addr); end
        I_stall_in = 1'b1;
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL dstall_req_hold got %b want 1", mem_req); end
        mem_ready = 1'b1; mem_data = LINE_2000;
        @(negedge clk); mem_ready = 1'b0; #1;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL dstall_done_req got %b want 0", mem_req); end
        vecs++; if (I_instruction !== 32'h20000000) begin errs++; $display("FAIL dstall_done_instr got %h want 20000000", I_instruction); end
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL dstall_done_stall got %b want 1", I_stall); end
        I_stall_in = 1'b0; #1;
        vecs++; if (I_stall !== 1'b0) begin errs++; $display("FAIL dstall_release_stall got %b want 0", I_stall); end
    endtask

    task automatic test_flush();
        @(negedge clk); I_flush = 1'b1;
        @(negedge clk); I_flush = 1'b0; #1;
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL flush_stall got %b want 1", I_stall); end
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL flush_instr got %h want 0", I_instruction); end
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errs++; $display("FAIL flush_req got req=%b addr=%h want req=1 addr=2000", mem_req, mem_addr); end
        mem_ready = 1'b1; mem_data = LINE_2000; I_flush = 1'b1;
        @(negedge clk); mem_ready = 1'b0; I_flush = 1'b0; #1;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL flushfill_idle_req got %b want 0", mem_req); end
        vecs++; if (I_stall !== 1'b1) begin errs++; $display("FAIL flushfill_stall got %b want 1", I_stall); end
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL flushfill_instr got %h want 0", I_instruction); end
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL flushfill_rereq got %b want 1", mem_req); end
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        vecs++; if (I_instruction !== 32'h20000000 || I_stall !== 1'b0) begin errs++; $display("FAIL flushfill_hit got instr=%h stall=%b want 20000000/0", I_instruction, I_stall); end
    endtask

    task automatic test_reset_midfill();
        @(negedge clk); pc = 32'h3000;
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL abort_pre_req got %b want 1", mem_req); end
        #2 reset = 1'b0; #1;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL abort_req got %b want 0", mem_req); end
        vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL abort_addr got %h want 0", mem_addr); end
        vecs++; if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin errs++; $display("FAIL abort_counters got hits=%0d misses=%0d want 0/0", perf_hits, perf_misses); end
        @(negedge clk); reset = 1'b1; I_stall_in = 1'b1; mem_ready = 1'b1; mem_data = LINE_3000;
        @(negedge clk); mem_ready = 1'b0; #1;
        vecs++; if (I_instruction !== 32'h0) begin errs++; $display("FAIL stale_ready_instr got %h want 0", I_instruction); end
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL stale_ready_req got %b want 0", mem_req); end
        vecs++; if (perf_misses !== 32'h0) begin errs++; $display("FAIL stale_ready_misses got %0d want 0", perf_misses); end
    endtask

    task automatic test_wrap();
        @(negedge clk); I_stall_in = 1'b0;
        @(negedge clk); mem_ready = 1'b1; mem_data = LINE_3000;
        @(negedge clk); mem_ready = 1'b0; I_stall_in = 1'b1; #1;
        vecs++; if (I_instruction !== 32'h30000000) begin errs++; $display("FAIL wrap_fill_instr got %h want 30000000", I_instruction); end
        vecs++; if (perf_misses !== 32'd1 || perf_hits !== 32'd0) begin errs++; $display("FAIL wrap_pre_counts got hits=%0d misses=%0d want 0/1", perf_hits, perf_misses); end
        force dut.hits_q = 32'hFFFFFFFF;
        #1 release dut.hits_q;
        @(negedge clk); I_stall_in = 1'b0;
        @(negedge clk); I_stall_in = 1'b1; #1;
        vecs++; if (perf_hits !== 32'h0) begin errs++; $display("FAIL wrap_hits got %h want 0", perf_hits); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        pc         = 32'h1000;
        I_stall_in = 1'b0;
        I_flush    = 1'b0;
        mem_ready  = 1'b0;
        mem_data   = '0;
        test_reset();
        test_cold_miss();
        test_same_line_hits();
        test_conflict();
        test_downstream_stall();
        test_flush();
        test_reset_midfill();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
